// File: rtl/encoder_pkg.sv
// encoder_pkg: shared definitions for the quadrature encoder interface.
//   - AB_* : filtered {A,B} pin states
//   - step_e : per-cycle decode result (none / increment / decrement / illegal)
//   - *_DEF : default widths for counter, filter and period timer
//   - decode_step() : classifies a transition from the previous to the current AB state
package encoder_pkg;

  localparam int unsigned CNT_W_DEF  = 32;
  localparam int unsigned FILT_W_DEF = 8;
  localparam int unsigned PER_W_DEF  = 24;

  localparam logic [1:0] AB_00 = 2'b00;
  localparam logic [1:0] AB_01 = 2'b01;
  localparam logic [1:0] AB_10 = 2'b10;
  localparam logic [1:0] AB_11 = 2'b11;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_INC,
    STEP_DEC,
    STEP_ILLEGAL
  } step_e;

  // Successor of an AB state in the incrementing direction: 00->10->11->01->00.
  function automatic logic [1:0] next_inc(input logic [1:0] ab);
    logic [1:0] nxt;
    case (ab)
      AB_00:   nxt = AB_10;
      AB_10:   nxt = AB_11;
      AB_11:   nxt = AB_01;
      default: nxt = AB_00;
    endcase
    return nxt;
  endfunction

  function automatic step_e decode_step(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
    step_e s;
    if (cur_ab == prev_ab) begin
      s = STEP_NONE;
    end else if ((cur_ab ^ prev_ab) == 2'b11) begin
      s = STEP_ILLEGAL;
    end else if (cur_ab == next_inc(prev_ab)) begin
      s = STEP_INC;
    end else begin
      s = STEP_DEC;
    end
    return s;
  endfunction

endpackage

// File: rtl/encoder_filter.sv
// encoder_filter: two-flop synchroniser followed by a stability filter for one encoder pin.
// A new synchronised level is accepted once it has differed from the filtered output on
// filt_len+1 consecutive clocks; shorter pulses are discarded.
// Ports:
//   clk, rst_n : fabric clock, asynchronous active-low reset
//   pin        : raw asynchronous pin
//   filt_len   : hold length in cycles (0 = accept after one cycle)
//   filtered   : synchronised, filtered pin level
module encoder_filter
  import encoder_pkg::*;
#(
  parameter int unsigned FILT_W = FILT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pin,
  input  logic [FILT_W-1:0] filt_len,
  output logic              filtered
);

  logic              sync1_q, sync2_q;
  logic              filt_q, filt_d;
  logic [FILT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == filt_len) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + FILT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pin;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filtered = filt_q;

endmodule

// File: rtl/encoder_qep.sv
// encoder_qep: quadrature encoder interface with x4 decoding, index handling and step-period
// measurement.
// Ports:
//   clk, rst_n   : fabric clock, asynchronous active-low reset
//   a, b, z      : raw encoder pins
//   filt_len     : glitch filter hold length for all pins
//   ppr_bits     : log2 of counts per revolution, sets the position wrap point
//   err_clr      : pulse to clear err_illegal
//   counter      : free-running step count (wraps)
//   position     : single-revolution position, all ones until the first index
//   pos_valid    : set by the first index rise
//   dir          : direction of the last step (1 = increment)
//   index_latch  : counter value captured at the index rise
//   index_cnt    : number of index rises seen
//   step_period  : clocks between the last two steps, all ones when stopped/unknown
//   err_illegal  : sticky flag for a transition where A and B changed together
module encoder_qep
  import encoder_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned FILT_W = FILT_W_DEF,
  parameter int unsigned PER_W  = PER_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a,
  input  logic              b,
  input  logic              z,
  input  logic [FILT_W-1:0] filt_len,
  input  logic [5:0]        ppr_bits,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  counter,
  output logic [CNT_W-1:0]  position,
  output logic              pos_valid,
  output logic              dir,
  output logic [CNT_W-1:0]  index_latch,
  output logic [15:0]       index_cnt,
  output logic [PER_W-1:0]  step_period,
  output logic              err_illegal
);

  logic             a_f, b_f, z_f;
  logic [1:0]       prev_ab_q;
  logic             z_prev_q;
  step_e            step;
  logic             step_inc, step_dec, step_any, z_rise;
  logic [5:0]       ppr_eff;
  logic [CNT_W-1:0] pos_max;

  logic [CNT_W-1:0] counter_q, counter_d;
  logic [CNT_W-1:0] position_q, position_d;
  logic             pos_valid_q, pos_valid_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] index_latch_q, index_latch_d;
  logic [15:0]      index_cnt_q, index_cnt_d;
  logic [PER_W-1:0] period_q, period_d;
  logic [PER_W-1:0] timer_q, timer_d;
  logic             err_q, err_d;

  encoder_filter #(.FILT_W(FILT_W)) u_filt_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .pin      (a),
    .filt_len (filt_len),
    .filtered (a_f)
  );

  encoder_filter #(.FILT_W(FILT_W)) u_filt_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .pin      (b),
    .filt_len (filt_len),
    .filtered (b_f)
  );

  encoder_filter #(.FILT_W(FILT_W)) u_filt_z (
    .clk      (clk),
    .rst_n    (rst_n),
    .pin      (z),
    .filt_len (filt_len),
    .filtered (z_f)
  );

  // Decode is combinational so the step lands on the edge right after the filter moves.
  assign step     = decode_step(prev_ab_q, {a_f, b_f});
  assign step_inc = (step == STEP_INC);
  assign step_dec = (step == STEP_DEC);
  assign step_any = step_inc | step_dec;
  assign z_rise   = z_f & ~z_prev_q;

  // Wrap point; recomputed every cycle so a ppr_bits change applies from the next step.
  assign ppr_eff = (ppr_bits == 6'd0) ? 6'd1 : ppr_bits;
  always_comb begin
    if (32'(ppr_bits) >= CNT_W) begin
      pos_max = '1;
    end else begin
      pos_max = (CNT_W'(1) << ppr_eff) - CNT_W'(1);
    end
  end

  always_comb begin
    counter_d     = counter_q;
    dir_d         = dir_q;
    position_d    = position_q;
    pos_valid_d   = pos_valid_q;
    index_latch_d = index_latch_q;
    index_cnt_d   = index_cnt_q;

    if (step_inc) begin
      counter_d = counter_q + CNT_W'(1);
      dir_d     = 1'b1;
    end else if (step_dec) begin
      counter_d = counter_q - CNT_W'(1);
      dir_d     = 1'b0;
    end

    // Index overrides any simultaneous position step.
    if (z_rise) begin
      position_d    = '0;
      pos_valid_d   = 1'b1;
      index_latch_d = counter_q;
      index_cnt_d   = index_cnt_q + 16'd1;
    end else if (pos_valid_q) begin
      if (step_inc) begin
        position_d = (position_q >= pos_max) ? '0 : position_q + CNT_W'(1);
      end else if (step_dec) begin
        position_d = (position_q == '0) ? pos_max : position_q - CNT_W'(1);
      end
    end
  end

  always_comb begin
    timer_d  = (timer_q == '1) ? timer_q : timer_q + PER_W'(1);
    period_d = period_q;
    if (step_any) begin
      period_d = timer_q;
      timer_d  = PER_W'(1);
    end else if (timer_q == '1) begin
      period_d = '1;
    end
  end

  // Set has priority over clear.
  always_comb begin
    err_d = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (step == STEP_ILLEGAL) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_ab_q     <= AB_00;
      z_prev_q      <= 1'b0;
      counter_q     <= '0;
      position_q    <= '1;
      pos_valid_q   <= 1'b0;
      dir_q         <= 1'b0;
      index_latch_q <= '0;
      index_cnt_q   <= '0;
      period_q      <= '1;
      timer_q       <= '0;
      err_q         <= 1'b0;
    end else begin
      prev_ab_q     <= {a_f, b_f};
      z_prev_q      <= z_f;
      counter_q     <= counter_d;
      position_q    <= position_d;
      pos_valid_q   <= pos_valid_d;
      dir_q         <= dir_d;
      index_latch_q <= index_latch_d;
      index_cnt_q   <= index_cnt_d;
      period_q      <= period_d;
      timer_q       <= timer_d;
      err_q         <= err_d;
    end
  end

  assign counter     = counter_q;
  assign position    = position_q;
  assign pos_valid   = pos_valid_q;
  assign dir         = dir_q;
  assign index_latch = index_latch_q;
  assign index_cnt   = index_cnt_q;
  assign step_period = period_q;
  assign err_illegal = err_q;

endmodule

// File: tb/tb_encoder_qep.sv
// Directed bench for encoder_qep. Inputs are driven and outputs sampled on the falling edge.
// PER_W is reduced so that timer saturation can be reached in a few hundred cycles.
module tb_encoder_qep;

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned FILT_W = 8;
  localparam int unsigned PER_W  = 8;

  logic              clk      = 1'b0;
  logic              rst_n    = 1'b1;
  logic              a        = 1'b0;
  logic              b        = 1'b0;
  logic              z        = 1'b0;
  logic [FILT_W-1:0] filt_len = '0;
  logic [5:0]        ppr_bits = 6'd2;
  logic              err_clr  = 1'b0;
  logic [CNT_W-1:0]  counter;
  logic [CNT_W-1:0]  position;
  logic              pos_valid;
  logic              dir;
  logic [CNT_W-1:0]  index_latch;
  logic [15:0]       index_cnt;
  logic [PER_W-1:0]  step_period;
  logic              err_illegal;

  int n_cmp = 0;
  int n_bad = 0;
  int phase = 0;

  always #5 clk = ~clk;

  encoder_qep #(
    .CNT_W  (CNT_W),
    .FILT_W (FILT_W),
    .PER_W  (PER_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a           (a),
    .b           (b),
    .z           (z),
    .filt_len    (filt_len),
    .ppr_bits    (ppr_bits),
    .err_clr     (err_clr),
    .counter     (counter),
    .position    (position),
    .pos_valid   (pos_valid),
    .dir         (dir),
    .index_latch (index_latch),
    .index_cnt   (index_cnt),
    .step_period (step_period),
    .err_illegal (err_illegal)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Forward order of the AB pair: 00 -> 10 -> 11 -> 01.
  function automatic logic [1:0] ab_of(input int p);
    logic [1:0] v;
    case (p)
      0:       v = 2'b00;
      1:       v = 2'b10;
      2:       v = 2'b11;
      default: v = 2'b01;
    endcase
    return v;
  endfunction

  task automatic step_fwd();
    phase = (phase + 1) % 4;
    {a, b} = ab_of(phase);
  endtask

  task automatic step_rev();
    phase = (phase + 3) % 4;
    {a, b} = ab_of(phase);
  endtask

  task automatic apply_reset();
    rst_n   = 1'b0;
    a       = 1'b0;
    b       = 1'b0;
    z       = 1'b0;
    err_clr = 1'b0;
    phase   = 0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic check_reset(input string pfx);
    check_eq({pfx, "_counter"},     64'(counter),     64'h0);
    check_eq({pfx, "_position"},    64'(position),    64'hFFFF_FFFF);
    check_eq({pfx, "_pos_valid"},   64'(pos_valid),   64'h0);
    check_eq({pfx, "_dir"},         64'(dir),         64'h0);
    check_eq({pfx, "_index_latch"}, 64'(index_latch), 64'h0);
    check_eq({pfx, "_index_cnt"},   64'(index_cnt),   64'h0);
    check_eq({pfx, "_step_period"}, 64'(step_period), 64'hFF);
    check_eq({pfx, "_err_illegal"}, 64'(err_illegal), 64'h0);
  endtask

  initial begin
    #1;
    apply_reset();
    check_reset("rst");

    // 1: 24 forward edges, 10 clocks apart, then an index pulse.
    filt_len = 8'd0;
    ppr_bits = 6'd2;
    for (int i = 0; i < 24; i++) begin
      step_fwd();
      tick(10);
    end
    check_eq("t1_counter", 64'(counter), 64'd24);
    check_eq("t1_dir", 64'(dir), 64'd1);
    check_eq("t1_period", 64'(step_period), 64'd10);
    check_eq("t1_pos_before_z", 64'(position), 64'hFFFF_FFFF);
    z = 1'b1;
    tick(6);
    z = 1'b0;
    check_eq("t1_position", 64'(position), 64'd0);
    check_eq("t1_pos_valid", 64'(pos_valid), 64'd1);
    check_eq("t1_index_latch", 64'(index_latch), 64'd24);
    check_eq("t1_index_cnt", 64'(index_cnt), 64'd1);
    tick(6);

    // 2: reverse motion before and after the index.
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      step_rev();
      tick(10);
    end
    check_eq("t2_counter", 64'(counter), 64'hFFFF_FFFB);
    check_eq("t2_position", 64'(position), 64'hFFFF_FFFF);
    check_eq("t2_dir", 64'(dir), 64'd0);
    z = 1'b1;
    tick(6);
    z = 1'b0;
    check_eq("t2_index_latch", 64'(index_latch), 64'hFFFF_FFFB);
    check_eq("t2_pos_at_z", 64'(position), 64'd0);
    step_rev();
    tick(6);
    check_eq("t2_pos_wrap", 64'(position), 64'd3);
    check_eq("t2_counter_after", 64'(counter), 64'hFFFF_FFFA);

    // 3: filter with filt_len = 4.
    apply_reset();
    filt_len = 8'd4;
    a = 1'b1;
    tick(3);
    a = 1'b0;
    tick(15);
    check_eq("t3_glitch_counter", 64'(counter), 64'd0);
    step_fwd();
    tick(7);
    check_eq("t3_not_yet", 64'(counter), 64'd0);
    tick(1);
    check_eq("t3_step_at_8", 64'(counter), 64'd1);
    check_eq("t3_dir", 64'(dir), 64'd1);

    // 4: illegal transitions and error clear priority.
    apply_reset();
    filt_len = 8'd0;
    {a, b} = 2'b11;
    phase = 2;
    tick(6);
    check_eq("t4_err_set", 64'(err_illegal), 64'd1);
    check_eq("t4_no_step", 64'(counter), 64'd0);
    {a, b} = 2'b00;
    phase = 0;
    tick(3);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check_eq("t4_set_wins", 64'(err_illegal), 64'd1);
    tick(2);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check_eq("t4_cleared", 64'(err_illegal), 64'd0);
    check_eq("t4_counter", 64'(counter), 64'd0);

    // 5: period timer, first step after reset and saturation.
    apply_reset();
    tick(2);
    step_fwd();
    tick(6);
    check_eq("t5_first_period", 64'(step_period), 64'd5);
    tick(300);
    check_eq("t5_stopped", 64'(step_period), 64'hFF);
    step_fwd();
    tick(6);
    check_eq("t5_after_sat", 64'(step_period), 64'hFF);
    check_eq("t5_counter", 64'(counter), 64'd2);
    tick(4);
    step_fwd();
    tick(6);
    check_eq("t5_restart", 64'(step_period), 64'd10);

    // 6: asynchronous reset mid-sequence, then index coincident with a step.
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      step_fwd();
      tick(10);
    end
    z = 1'b1;
    tick(6);
    z = 1'b0;
    step_fwd();
    tick(1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    a = 1'b0;
    b = 1'b0;
    z = 1'b0;
    phase = 0;
    #1;
    check_reset("arst");
    tick(1);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step_fwd();
      tick(10);
    end
    z = 1'b1;
    step_fwd();
    tick(6);
    z = 1'b0;
    check_eq("t6_counter", 64'(counter), 64'd3);
    check_eq("t6_position", 64'(position), 64'd0);
    check_eq("t6_pos_valid", 64'(pos_valid), 64'd1);
    check_eq("t6_index_latch", 64'(index_latch), 64'd2);
    check_eq("t6_dir", 64'(dir), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
